// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the instruction fetch unit, instruction memory and the
// IR/decode stage. The fetch unit is the master: it drives the memory
// request and the instruction offer. The slave side answers memory requests
// and accepts instructions.
interface instr_fetch_unit_if #(
    parameter int WORD_WIDTH = 32
) ();

    // Instruction memory read channel
    logic                  mem_req;
    logic [WORD_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [WORD_WIDTH-1:0] mem_rdata;

    // Instruction delivery channel towards the IR/decode stage
    logic                  instr_valid;
    logic                  instr_ready;
    logic [WORD_WIDTH-1:0] instr_out;
    logic [WORD_WIDTH-1:0] pc_out;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        output instr_valid,
        input  instr_ready,
        output instr_out,
        output pc_out
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr_out,
        input  pc_out
    );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit. Owns the PC, issues one word read at a time to
// instruction memory over req/ack, parks the returned word together with
// its PC in output registers and offers it downstream over valid/ready.
// Branch/jump redirects reload the PC; a redirect that lands while a read is
// outstanding marks that read as killed so its data is dropped on arrival.
// There is no prefetch: a new read is only issued once the previous
// instruction has been handed off (or dropped by a redirect).
module instr_fetch_unit #(
    parameter int                    WORD_WIDTH = 32,
    parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [WORD_WIDTH-1:0] redirect_pc,
    instr_fetch_unit_if.master    bus
);

    // Clearing the two low bits keeps every PC and memory address word aligned.
    localparam logic [WORD_WIDTH-1:0] ALIGN_MASK = ~WORD_WIDTH'(3);
    localparam logic [WORD_WIDTH-1:0] STEP       = WORD_WIDTH'(PC_STEP);

    // IDLE: nothing outstanding, nothing held.
    // REQ : a read is on the bus (mem_req=1), waiting for mem_ack.
    // HOLD: an instruction sits in the output registers waiting for ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                state_reg,       state_next;
    logic [WORD_WIDTH-1:0] pc_reg,          pc_next;
    logic                  kill_reg,        kill_next;
    logic                  mem_req_reg,     mem_req_next;
    logic [WORD_WIDTH-1:0] mem_addr_reg,    mem_addr_next;
    logic                  instr_valid_reg, instr_valid_next;
    logic [WORD_WIDTH-1:0] instr_out_reg,   instr_out_next;
    logic [WORD_WIDTH-1:0] pc_out_reg,      pc_out_next;

    logic [WORD_WIDTH-1:0] redirect_target;
    logic [WORD_WIDTH-1:0] pc_seq;

    // Aligned redirect target and the sequential successor of the current PC
    // (the add wraps naturally modulo 2^WORD_WIDTH).
    always_comb begin
        redirect_target = redirect_pc & ALIGN_MASK;
        pc_seq          = (pc_reg + STEP) & ALIGN_MASK;
    end

    // State register and all registered outputs; RST wins over everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_PC & ALIGN_MASK;
            kill_reg        <= 1'b0;
            mem_req_reg     <= 1'b0;
            mem_addr_reg    <= RESET_PC & ALIGN_MASK;
            instr_valid_reg <= 1'b0;
            instr_out_reg   <= '0;
            pc_out_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            kill_reg        <= kill_next;
            mem_req_reg     <= mem_req_next;
            mem_addr_reg    <= mem_addr_next;
            instr_valid_reg <= instr_valid_next;
            instr_out_reg   <= instr_out_next;
            pc_out_reg      <= pc_out_next;
        end
    end

    // Next-state and next-output logic. Redirect always takes priority over
    // the sequential PC update. Whenever a new read is launched, mem_addr is
    // loaded from the PC value that will be current in the next cycle, so a
    // redirect arriving on the launch edge is fetched immediately.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        kill_next        = kill_reg;
        mem_req_next     = mem_req_reg;
        mem_addr_next    = mem_addr_reg;
        instr_valid_next = instr_valid_reg;
        instr_out_next   = instr_out_reg;
        pc_out_next      = pc_out_reg;

        unique case (state_reg)
            IDLE: begin
                mem_req_next     = 1'b0;
                instr_valid_next = 1'b0;
                if (redirect_valid) begin
                    pc_next = redirect_target;
                end
                if (fetch_en) begin
                    state_next    = REQ;
                    mem_req_next  = 1'b1;
                    mem_addr_next = pc_next & ALIGN_MASK;
                end
            end

            REQ: begin
                // The address stays on the bus until the ack; fetch_en is
                // ignored here so an issued read is never abandoned.
                if (redirect_valid) begin
                    pc_next = redirect_target;
                end
                if (bus.mem_ack) begin
                    mem_req_next = 1'b0;
                    if (kill_reg || redirect_valid) begin
                        // Stale data: drop it. Going through IDLE leaves
                        // mem_req low for exactly one cycle before the
                        // re-fetch at the new PC (if fetch_en still allows).
                        kill_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        instr_out_next   = bus.mem_rdata;
                        pc_out_next      = pc_reg;
                        instr_valid_next = 1'b1;
                        state_next       = HOLD;
                    end
                end else if (redirect_valid) begin
                    // Remember that the outstanding read is now stale.
                    kill_next = 1'b1;
                end
            end

            HOLD: begin
                if (redirect_valid || bus.instr_ready) begin
                    // A redirect drops the held instruction even if the
                    // consumer was ready in the same cycle.
                    pc_next          = redirect_valid ? redirect_target : pc_seq;
                    instr_valid_next = 1'b0;
                    if (fetch_en) begin
                        state_next    = REQ;
                        mem_req_next  = 1'b1;
                        mem_addr_next = pc_next & ALIGN_MASK;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next       = IDLE;
                kill_next        = 1'b0;
                mem_req_next     = 1'b0;
                instr_valid_next = 1'b0;
            end
        endcase
    end

    assign bus.mem_req     = mem_req_reg;
    assign bus.mem_addr    = mem_addr_reg;
    assign bus.instr_valid = instr_valid_reg;
    assign bus.instr_out   = instr_out_reg;
    assign bus.pc_out      = pc_out_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios followed by a random
// soak. A memory responder with configurable latency and a PC reference
// model (delivered PC sequence, redirect targets, kill of stale reads) live
// in the bench; every cycle the observed bus is checked against them.
module tb_instr_fetch_unit;

    localparam int          W        = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    instr_fetch_unit_if #(.WORD_WIDTH(W)) bus ();

    instr_fetch_unit #(
        .WORD_WIDTH (W),
        .RESET_PC   (RESET_PC),
        .PC_STEP    (4)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int delivered = 0;

    // Reference model and memory responder state
    logic [31:0] exp_pc = RESET_PC;
    bit          req_killed = 1'b0;
    int          lat_cnt = 0;
    int          lat_cfg = 0;
    bit          rand_lat = 1'b0;
    bit          force_ack = 1'b0;

    // Snapshot of what the DUT sees at the coming edge
    logic        p_rst, p_req, p_ack, p_valid, p_ready, p_redir;
    logic [31:0] p_addr, p_iout, p_pcout, p_target;

    // Instruction memory contents: address 0 holds the test-plan word,
    // everything else an address-derived pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: snapshot inputs/outputs, take the edge, check the new
    // outputs against the model, then drive memory for the new cycle.
    task automatic cycle();
        p_rst    = RST;
        p_req    = bus.mem_req;
        p_ack    = bus.mem_ack;
        p_valid  = bus.instr_valid;
        p_ready  = bus.instr_ready;
        p_redir  = redirect_valid;
        p_addr   = bus.mem_addr;
        p_iout   = bus.instr_out;
        p_pcout  = bus.pc_out;
        p_target = redirect_pc & 32'hFFFF_FFFC;
        @(posedge CLK);
        #1;
        redirect_valid = 1'b0;
        if (p_rst) begin
            exp_pc     = RESET_PC;
            req_killed = 1'b0;
        end else begin
            if (p_valid && p_ready && !p_redir) begin
                delivered++;
                check("deliver_pc", p_pcout, exp_pc);
                check("deliver_instr", p_iout, mem_word(p_pcout));
            end
            if (p_valid) begin
                if (p_ready || p_redir) begin
                    check("valid_drop", 32'(bus.instr_valid), 32'd0);
                end else begin
                    check("hold_valid", 32'(bus.instr_valid), 32'd1);
                    check("hold_instr", bus.instr_out, p_iout);
                    check("hold_pc", bus.pc_out, p_pcout);
                end
            end
            if (p_req) begin
                if (p_redir) req_killed = 1'b1;
                if (p_ack) begin
                    check("req_release", 32'(bus.mem_req), 32'd0);
                    check("capture", 32'(bus.instr_valid), req_killed ? 32'd0 : 32'd1);
                    req_killed = 1'b0;
                end else begin
                    check("req_stable", 32'(bus.mem_req), 32'd1);
                    check("addr_stable", bus.mem_addr, p_addr);
                end
            end
            if (p_redir) exp_pc = p_target;
            else if (p_valid && p_ready) exp_pc = exp_pc + 32'd4;
            if (bus.mem_req && !p_req) begin
                check("issue_addr", bus.mem_addr, exp_pc);
                req_killed = 1'b0;
            end
            if (bus.mem_req) begin
                check("addr_align", 32'(bus.mem_addr[1:0]), 32'd0);
                check("req_xor_valid", 32'(bus.instr_valid), 32'd0);
            end
        end
        if (bus.mem_req) begin
            if (!p_req || p_rst) lat_cnt = rand_lat ? int'($urandom_range(0, 3)) : lat_cfg;
            else if (lat_cnt > 0) lat_cnt--;
            bus.mem_ack   = (lat_cnt == 0);
            bus.mem_rdata = mem_word(bus.mem_addr);
        end else begin
            bus.mem_ack   = force_ack;
            bus.mem_rdata = force_ack ? 32'hDEAD_BEEF : 32'h0;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        fetch_en = 1'b0;
        bus.instr_ready = 1'b0;
        force_ack = 1'b0;
        cycle();
        cycle();
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_addr", bus.mem_addr, RESET_PC);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr_out", bus.instr_out, 32'd0);
        check("rst_pc_out", bus.pc_out, 32'd0);
        RST = 1'b0;
    endtask

    int          n;
    logic [31:0] saved;

    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        bus.instr_ready = 1'b0;

        // Basic zero-wait fetch and throughput timing
        do_reset();
        rand_lat = 1'b0;
        lat_cfg = 0;
        fetch_en = 1'b1;
        bus.instr_ready = 1'b1;
        cycle();
        check("t1_req", 32'(bus.mem_req), 32'd1);
        check("t1_addr", bus.mem_addr, 32'h0);
        cycle();
        check("t1_valid", 32'(bus.instr_valid), 32'd1);
        check("t1_instr", bus.instr_out, 32'h2008_0005);
        check("t1_pc", bus.pc_out, 32'h0);
        cycle();
        check("t1_next_req", 32'(bus.mem_req), 32'd1);
        check("t1_next_addr", bus.mem_addr, 32'h4);

        // Backpressure in HOLD for 5 cycles
        bus.instr_ready = 1'b0;
        cycle();
        check("t2_valid", 32'(bus.instr_valid), 32'd1);
        saved = bus.instr_out;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t2_hold_valid", 32'(bus.instr_valid), 32'd1);
            check("t2_hold_req", 32'(bus.mem_req), 32'd0);
            check("t2_hold_instr", bus.instr_out, saved);
            check("t2_hold_pc", bus.pc_out, 32'h4);
        end
        lat_cfg = 3;
        bus.instr_ready = 1'b1;
        cycle();
        check("t2_step_addr", bus.mem_addr, 32'h8);
        bus.instr_ready = 1'b0;

        // Wait states: ack three cycles late
        n = 1;
        for (int i = 0; i < 10 && bus.mem_req; i++) begin
            cycle();
            if (bus.mem_req) begin
                n++;
                check("t3_addr", bus.mem_addr, 32'h8);
            end
        end
        check("t3_req_cycles", 32'(n), 32'd4);
        check("t3_valid", 32'(bus.instr_valid), 32'd1);
        check("t3_pc", bus.pc_out, 32'h8);

        // Redirect while a read is outstanding
        do_reset();
        lat_cfg = 3;
        fetch_en = 1'b1;
        bus.instr_ready = 1'b1;
        cycle();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        cycle();
        for (int i = 0; i < 10 && bus.mem_req; i++) begin
            cycle();
            check("t4_no_valid", 32'(bus.instr_valid), 32'd0);
        end
        check("t4_gap_req", 32'(bus.mem_req), 32'd0);
        cycle();
        check("t4_rereq", 32'(bus.mem_req), 32'd1);
        check("t4_readdr", bus.mem_addr, 32'h100);
        for (int i = 0; i < 10 && !bus.instr_valid; i++) cycle();
        check("t4_pc_out", bus.pc_out, 32'h100);
        check("t4_instr", bus.instr_out, mem_word(32'h100));

        // Redirect in HOLD coinciding with ready
        do_reset();
        lat_cfg = 0;
        fetch_en = 1'b1;
        cycle();
        cycle();
        check("t5_valid", 32'(bus.instr_valid), 32'd1);
        bus.instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        cycle();
        check("t5_dropped", 32'(bus.instr_valid), 32'd0);
        check("t5_req", 32'(bus.mem_req), 32'd1);
        check("t5_addr", bus.mem_addr, 32'h40);

        // PC wrap, then reset in the middle of a read
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cycle();
        fetch_en = 1'b1;
        bus.instr_ready = 1'b1;
        cycle();
        check("t6_addr_top", bus.mem_addr, 32'hFFFF_FFFC);
        cycle();
        check("t6_pc_top", bus.pc_out, 32'hFFFF_FFFC);
        cycle();
        check("t6_wrap_addr", bus.mem_addr, 32'h0);
        cycle();
        lat_cfg = 5;
        cycle();
        check("t6_addr4", bus.mem_addr, 32'h4);
        RST = 1'b1;
        cycle();
        check("t6_rst_req", 32'(bus.mem_req), 32'd0);
        check("t6_rst_valid", 32'(bus.instr_valid), 32'd0);
        check("t6_rst_addr", bus.mem_addr, RESET_PC);
        RST = 1'b0;
        fetch_en = 1'b0;
        force_ack = 1'b1;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        cycle();
        force_ack = 1'b0;
        check("t6_late_ack_valid", 32'(bus.instr_valid), 32'd0);
        check("t6_late_ack_req", 32'(bus.mem_req), 32'd0);
        cycle();
        check("t6_idle_valid", 32'(bus.instr_valid), 32'd0);

        // Random soak against the reference model
        do_reset();
        rand_lat = 1'b1;
        n = delivered;
        for (int i = 0; i < 3000; i++) begin
            fetch_en = ($urandom_range(0, 9) != 0);
            bus.instr_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = $urandom;
            end
            cycle();
        end
        check("soak_progress", 32'((delivered - n) > 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
